// File: rtl/raccoon_input_ctrl_if.sv
// Button and step-request bundle between the board switch pins and the raccoon movement logic.
// The controller connects to the slave side; the pin/stimulus side connects to the master side.
interface raccoon_input_ctrl_if;
    logic i_Btn_Up;
    logic i_Btn_Dn;
    logic i_Btn_Lt;
    logic i_Btn_Rt;
    logic i_Enable;
    logic o_Step_Up;
    logic o_Step_Dn;
    logic o_Step_Lt;
    logic o_Step_Rt;
    logic o_Any_Held;

    modport master (
        output i_Btn_Up, i_Btn_Dn, i_Btn_Lt, i_Btn_Rt, i_Enable,
        input  o_Step_Up, o_Step_Dn, o_Step_Lt, o_Step_Rt, o_Any_Held
    );

    modport slave (
        input  i_Btn_Up, i_Btn_Dn, i_Btn_Lt, i_Btn_Rt, i_Enable,
        output o_Step_Up, o_Step_Dn, o_Step_Lt, o_Step_Rt, o_Any_Held
    );
endinterface

// File: rtl/raccoon_input_ctrl.sv
// Synchronises and debounces the four movement buttons, then arbitrates them into
// single-cycle step pulses with auto-repeat while the owning direction stays held.
//
// state  | meaning
// IDLE   | no owner; waiting for a fresh press while enabled
// DELAY  | owner stepped; waiting REPEAT_DELAY cycles for the first auto-repeat
// REPEAT | owner auto-repeating every REPEAT_PERIOD cycles
module raccoon_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    raccoon_input_ctrl_if.slave  bus
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TC = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Bit order doubles as priority: index 0 (up) wins over higher indices.
    logic [3:0]      btn_raw;
    logic [3:0]      sync_1;
    logic [3:0]      sync_2;
    logic [3:0]      level;
    logic [3:0]      level_d;
    logic [3:0]      rise;
    logic [DB_W-1:0] db_cnt [4];

    state_t           state;
    logic [1:0]       owner;
    logic [RPT_W-1:0] rpt_cnt;
    logic [3:0]       step;

    logic [1:0] rise_sel;
    logic       rise_any;
    logic [3:0] pre_mask;
    logic       take_over;

    assign btn_raw = {bus.i_Btn_Rt, bus.i_Btn_Lt, bus.i_Btn_Dn, bus.i_Btn_Up};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_1  <= '0;
            sync_2  <= '0;
            level   <= '0;
            level_d <= '0;
            rise    <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1  <= btn_raw;
            sync_2  <= sync_1;
            level_d <= level;
            rise    <= level & ~level_d;
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press that coincides with the owner's release is treated as a fresh press.
    always_comb begin
        rise_any = |rise;
        if (rise[0]) begin
            rise_sel = 2'd0;
        end else if (rise[1]) begin
            rise_sel = 2'd1;
        end else if (rise[2]) begin
            rise_sel = 2'd2;
        end else begin
            rise_sel = 2'd3;
        end
        pre_mask  = (4'b0001 << owner) - 4'b0001;
        take_over = (|(rise & pre_mask)) || (!level_d[owner] && rise_any);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= IDLE;
            owner   <= '0;
            rpt_cnt <= '0;
            step    <= '0;
        end else begin
            step <= '0;
            if (!bus.i_Enable) begin
                state   <= IDLE;
                rpt_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_any) begin
                            step    <= 4'b0001 << rise_sel;
                            owner   <= rise_sel;
                            rpt_cnt <= DLY_TC;
                            state   <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (take_over) begin
                            step    <= 4'b0001 << rise_sel;
                            owner   <= rise_sel;
                            rpt_cnt <= DLY_TC;
                            state   <= DELAY;
                        end else if (!level_d[owner]) begin
                            rpt_cnt <= '0;
                            state   <= IDLE;
                        end else if (rpt_cnt == '0) begin
                            step    <= 4'b0001 << owner;
                            rpt_cnt <= PER_TC;
                            state   <= REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt - 1'b1;
                        end
                    end
                    default: begin
                        rpt_cnt <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_Step_Up  = step[0];
    assign bus.o_Step_Dn  = step[1];
    assign bus.o_Step_Lt  = step[2];
    assign bus.o_Step_Rt  = step[3];
    assign bus.o_Any_Held = |level;

endmodule

// File: tb/tb_raccoon_input_ctrl.sv
// Bench for raccoon_input_ctrl: directed scenarios with fixed pulse-edge expectations,
// then random button/enable/reset activity compared every cycle against a reference model.
module tb_raccoon_input_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    raccoon_input_ctrl_if bus ();

    raccoon_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int e0 = 0;
    int pq[$];
    int ex[$];
    logic held_seen = 1'b0;
    logic [3:0] btn = '0;

    // reference model state
    logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_d = '0, m_rise = '0, m_step = '0;
    int m_run[4] = '{0, 0, 0, 0};
    logic m_busy = 1'b0;
    int m_owner = 0;
    int m_next = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pk(input int edge_n, input int vec);
        return edge_n * 16 + vec;
    endfunction

    function automatic logic [3:0] dut_steps();
        return {bus.o_Step_Rt, bus.o_Step_Lt, bus.o_Step_Dn, bus.o_Step_Up};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] b);
        btn = b;
        bus.i_Btn_Up = b[0];
        bus.i_Btn_Dn = b[1];
        bus.i_Btn_Lt = b[2];
        bus.i_Btn_Rt = b[3];
    endtask

    task automatic mark();
        e0 = cyc + 1;
        pq.delete();
        held_seen = 1'b0;
    endtask

    task automatic expect_pulses(input string tag);
        chk({tag, "_count"}, pq.size(), ex.size());
        foreach (ex[i]) begin
            if (i < pq.size()) chk({tag, "_pulse"}, pq[i], ex[i]);
        end
    endtask

    // Reference model: pipeline of sync/debounce/press events, then arbitration with
    // absolute-cycle deadlines for the auto-repeat.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_rise = '0; m_step = '0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
            m_busy = 1'b0;
        end else begin
            int first;
            logic [3:0] raw;
            raw = {bus.i_Btn_Rt, bus.i_Btn_Lt, bus.i_Btn_Dn, bus.i_Btn_Up};
            m_step = '0;
            first = -1;
            for (int b = 3; b >= 0; b--) if (m_rise[b]) first = b;
            if (!bus.i_Enable) begin
                m_busy = 1'b0;
            end else if (first >= 0 && (!m_busy || first < m_owner || !m_lvl_d[m_owner])) begin
                m_step[first] = 1'b1;
                m_owner = first;
                m_busy = 1'b1;
                m_next = cyc + RD;
            end else if (m_busy && !m_lvl_d[m_owner]) begin
                m_busy = 1'b0;
            end else if (m_busy && cyc == m_next) begin
                m_step[m_owner] = 1'b1;
                m_next = cyc + RP;
            end
            m_rise = m_lvl & ~m_lvl_d;
            m_lvl_d = m_lvl;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = ~m_lvl[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("steps", dut_steps(), m_step);
        chk("any_held", bus.o_Any_Held, |m_lvl);
        chk("onehot", $countones(dut_steps()) <= 1, 1);
        if (dut_steps() != 4'b0000) pq.push_back(pk(cyc - e0, dut_steps()));
        if (bus.o_Any_Held) held_seen = 1'b1;
    end

    initial begin
        drive(4'b0000);
        bus.i_Enable = 1'b1;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        chk("reset_steps", dut_steps(), 0);
        chk("reset_any", bus.o_Any_Held, 0);
        cycles(5);

        // hold up: first step, delayed repeat, then periodic repeats
        mark();
        drive(4'b0001);
        cycles(61);
        ex = '{pk(7, 1), pk(27, 1), pk(35, 1), pk(43, 1), pk(51, 1), pk(59, 1)};
        expect_pulses("hold_up");
        drive(4'b0000);
        cycles(15);

        // 3-cycle glitch is filtered out
        mark();
        drive(4'b0001);
        cycles(3);
        drive(4'b0000);
        cycles(20);
        ex.delete();
        expect_pulses("glitch");
        chk("glitch_held", held_seen, 0);

        // simultaneous left+right: left wins, right never steps after left release
        mark();
        drive(4'b1100);
        cycles(15);
        drive(4'b1000);
        cycles(45);
        ex = '{pk(7, 4)};
        expect_pulses("lt_rt");
        drive(4'b0000);
        cycles(15);

        // right stepping, then up pre-empts it
        mark();
        drive(4'b1000);
        cycles(10);
        drive(4'b1001);
        cycles(40);
        ex = '{pk(7, 8), pk(17, 1), pk(37, 1), pk(45, 1)};
        expect_pulses("preempt");
        drive(4'b0000);
        cycles(15);

        // disabled while down held; enabling does not step until re-press
        bus.i_Enable = 1'b0;
        mark();
        drive(4'b0010);
        cycles(40);
        chk("dis_any_held", bus.o_Any_Held, 1);
        bus.i_Enable = 1'b1;
        cycles(30);
        drive(4'b0000);
        cycles(15);
        drive(4'b0010);
        cycles(25);
        ex = '{pk(92, 2)};
        expect_pulses("enable");
        drive(4'b0000);
        cycles(15);

        // reset during repeat with up held: full resync + debounce before next step
        mark();
        drive(4'b0001);
        cycles(40);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_steps", dut_steps(), 0);
        chk("mid_rst_any", bus.o_Any_Held, 0);
        rst = 1'b0;
        cycles(15);
        ex = '{pk(7, 1), pk(27, 1), pk(35, 1), pk(48, 1)};
        expect_pulses("reset_mid");
        drive(4'b0000);
        cycles(15);

        // random activity against the model
        for (int it = 0; it < 150; it++) begin
            int r;
            logic [3:0] nb;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst = 1'b1;
                cycles(1 + $urandom_range(0, 1));
                rst = 1'b0;
            end else if (r < 12) begin
                bus.i_Enable = ~bus.i_Enable;
            end else begin
                nb = btn;
                nb[$urandom_range(0, 3)] ^= 1'b1;
                drive(nb);
            end
            cycles($urandom_range(1, 35));
        end
        bus.i_Enable = 1'b1;
        drive(4'b0000);
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
